phase_frame_tx: RTL and testbench
=================================

# phase_frame_tx

Parametrised frame transmitter for the RF phase-control path: holds a loadable frame of up to MAX_BITS bits, serialises it at a fixed baud rate, and drives the single-bit phase_ctrl line with NRZ-L, NRZ-M or NRZ-S line coding. Supports one-shot or continuous (looping) transmission, abort, and an optional CCSDS pseudo-randomizer. Sits between the host/config logic that loads the frame and the RF generator gated by gen_en.

## Interface
- REF_CLK_FREQ, 128000000, clk frequency in Hz
- BAUDRATE, 9600, symbol rate; DIV = REF_CLK_FREQ/BAUDRATE (integer), DIV >= 2
- MAX_BITS, 1200, frame buffer capacity in bits
- WR_W, 32, frame buffer write word width; DEPTH = ceil(MAX_BITS/WR_W), AW = max(1,$clog2(DEPTH)), LW = $clog2(MAX_BITS+1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  frame buffer write strobe
- wr_addr  in  AW  word address; frame bit k = word k/WR_W, bit WR_W-1-(k%WR_W) (MSB first)
- wr_data  in  WR_W  write data
- frame_len  in  LW  frame length in bits, sampled at start
- mode  in  2  00 NRZ-L, 01 NRZ-M, 10 NRZ-S, 11 treated as NRZ-L; sampled at start
- continuous  in  1  loop frame; sampled live at each frame end
- send_signal  in  1  start request (level or pulse, acted on in IDLE only)
- abort  in  1  immediate stop
- busy  out  1  high in SEND/TAIL
- gen_en  out  1  equals busy
- bit_strobe  out  1  one-cycle pulse on each symbol update
- frame_done  out  1  one-cycle pulse at end of last symbol period
- phase_ctrl  out  1  line-coded output

## Operation
- States: IDLE, SEND, TAIL.
- IDLE + send_signal + !abort + frame_len != 0: latch len = min(frame_len, MAX_BITS), latch mode, clear baud counter and bit_idx, reseed randomizer, go SEND. frame_len == 0: stay IDLE.
- Baud counter runs 0..DIV-1 in SEND/TAIL only; tick when count == DIV-1.
- SEND, on tick: d = buf[bit_idx] (XOR randomizer if enabled), update phase_ctrl: NRZ-L: d; NRZ-M: toggle if d; NRZ-S: toggle if !d. Pulse bit_strobe. bit_idx++; if bit_idx == len-1 go TAIL.
- TAIL, on tick: pulse frame_done. If continuous: bit_idx = 0, reseed, emit bit 0 on this same tick (bit_strobe), go SEND (TAIL if len==1). Else go IDLE.
- abort: any state -> IDLE next edge; phase_ctrl holds; no frame_done. abort and send_signal together: stay IDLE.
- send_signal while busy: ignored. wr_en while busy: ignored (buffer immutable during transmission). wr_addr >= DEPTH: ignored.
- phase_ctrl holds its level in IDLE; NRZ-M/S continue from current level at next start.
- Reset: phase_ctrl = 1; busy, gen_en, bit_strobe, frame_done = 0; state IDLE; buffer contents = 0.

## Timing
- Start sampled at edge E0: busy/gen_en high after E0; first phase_ctrl update at edge E0+DIV; bit k at E0+(k+1)·DIV.
- Every symbol, including the last, lasts exactly DIV cycles; frame_done and busy-fall at E0+(len+1)·DIV (one-shot).
- Continuous: no gap between frames; frame_done coincides with bit_strobe of next frame's bit 0.
- Buffer write takes effect the edge after wr_en.

## Configuration
- PHASE_TX_SCRAMBLE_EN defined: CCSDS randomizer h(x)=x^8+x^7+x^5+x^3+1, seed 0xFF, XORed onto frame bits at index >= ASM_BITS (32), advanced once per such bit, reseeded per frame; ASM bits sent unmodified.
- Undefined: data sent raw; no randomizer logic.

## Structure
- Package phase_tx_pkg: mode encodings, state enum, ASM_BITS = 32, randomizer seed and taps.
- Sub-module phase_baud_gen: DIV-period counter with synchronous enable/clear, tick output.

## Test plan
(REF_CLK_FREQ=40, BAUDRATE=10 -> DIV=4, MAX_BITS=16, WR_W=8)
- Load word0=8'hA5, word1=8'h0F, len=16, NRZ-L, one-shot start -> phase_ctrl 1,0,1,0,0,1,0,1,0,0,0,0,1,1,1,1 at 4-cycle spacing starting 4 cycles after start; frame_done 68 cycles after start; busy falls same edge.
- Same data, NRZ-M, phase_ctrl reset 1 -> first 8 symbols 0,0,1,1,1,0,0,1.
- continuous=1, len=3 -> symbols repeat with no gap; frame_done every 12 cycles; drop continuous mid-frame -> stops after current frame.
- abort at cycle 10 of a frame -> IDLE next edge, phase_ctrl holds, no frame_done; simultaneous abort+send_signal -> stays IDLE.
- frame_len=0 -> no start; frame_len=20 -> clamped, 16 symbols; wr_en while busy -> buffer unchanged.
- PHASE_TX_SCRAMBLE_EN, MAX_BITS=48, ASM 1ACFFC1D then 16 zero bits, NRZ-L -> bits 32..47 = FF48 (1111_1111_0100_1000).

Source files
------------

// File: rtl/phase_tx_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | phase_tx_pkg : shared encodings and sizing helpers for phase_frame_tx     |
// | Revision     : 1.0                                                        |
// +---------------------------------------------------------------------------+
package phase_tx_pkg;

   typedef enum logic [1:0] {
      MODE_NRZL = 2'b00,
      MODE_NRZM = 2'b01,
      MODE_NRZS = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_TAIL = 2'd2;

   localparam int         ASM_BITS  = 32;
   localparam logic [7:0] RAND_SEED = 8'hFF;
   // Feedback taps of x^8+x^7+x^5+x^3+1 with state[0] as the oldest bit
   localparam logic [7:0] RAND_TAPS = 8'b1010_1001;

   function automatic int depth_of(int max_bits, int wr_w);
      return (max_bits + wr_w - 1) / wr_w;
   endfunction

   function automatic int aw_of(int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int lw_of(int max_bits);
      return $clog2(max_bits + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/phase_frame_tx_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | phase_frame_tx_if : host/config bus and RF-side outputs of phase_frame_tx |
// | Revision          : 1.0                                                   |
// +---------------------------------------------------------------------------+
interface phase_frame_tx_if
   import phase_tx_pkg::*;
#(
   parameter int MAX_BITS = 1200,
   parameter int WR_W     = 32
);
   localparam int AW = aw_of(depth_of(MAX_BITS, WR_W));
   localparam int LW = lw_of(MAX_BITS);

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [WR_W-1:0] wr_data;
   logic [LW-1:0]   frame_len;
   logic [1:0]      mode;
   logic            continuous;
   logic            send_signal;
   logic            abort;
   logic            busy;
   logic            gen_en;
   logic            bit_strobe;
   logic            frame_done;
   logic            phase_ctrl;

   modport master (
      output wr_en, wr_addr, wr_data, frame_len, mode, continuous, send_signal, abort,
      input  busy, gen_en, bit_strobe, frame_done, phase_ctrl
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, frame_len, mode, continuous, send_signal, abort,
      output busy, gen_en, bit_strobe, frame_done, phase_ctrl
   );

endinterface
`default_nettype wire

// File: rtl/phase_baud_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | phase_baud_gen : DIV-period counter, tick on the last count of a period   |
// | Revision       : 1.0                                                      |
// +---------------------------------------------------------------------------+
module phase_baud_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);
   localparam int CW = $clog2(DIV);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          w_last;

   assign w_last = (cnt_q == CW'(DIV - 1));
   assign tick_o = en_i && w_last;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = w_last ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/phase_frame_tx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | phase_frame_tx : frame buffer + NRZ-L/M/S serialiser for phase_ctrl;      |
// | optional CCSDS randomizer via PHASE_TX_SCRAMBLE_EN.  Revision : 1.0       |
// +---------------------------------------------------------------------------+
module phase_frame_tx
   import phase_tx_pkg::*;
#(
   parameter int REF_CLK_FREQ = 128000000,
   parameter int BAUDRATE     = 9600,
   parameter int MAX_BITS     = 1200,
   parameter int WR_W         = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   phase_frame_tx_if.slave  bus
);
   localparam int DIV  = REF_CLK_FREQ / BAUDRATE;
   localparam int LW   = lw_of(MAX_BITS);
   localparam int FLAT = 1 << LW;

   logic [1:0]    state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] bit_idx_q, bit_idx_d;
   mode_e         mode_q, mode_d;
   logic          phase_q, phase_d;
   logic          strobe_q, strobe_d;
   logic          done_q, done_d;

   logic          w_busy;
   logic          w_tick;
   logic          w_wr_en;
   logic [FLAT-1:0] w_bits;
   logic [LW-1:0] w_idx;
   logic          w_raw;
   logic          w_data;
   logic          w_phase_next;
   logic [LW-1:0] w_len_clamped;

   assign w_busy  = (state_q != ST_IDLE);
   assign w_wr_en = bus.wr_en && !w_busy;

   phase_baud_gen #(.DIV(DIV)) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (w_busy),
      .clr_i  (!w_busy || bus.abort),
      .tick_o (w_tick)
   );

   // Bit-addressed frame store; a word address past the buffer matches no bit
   for (genvar k = 0; k < FLAT; k++) begin : g_bit
      if (k < MAX_BITS) begin : g_store
         logic bit_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               bit_q <= 1'b0;
            end else if (w_wr_en && (32'(bus.wr_addr) == (k / WR_W))) begin
               bit_q <= bus.wr_data[WR_W-1-(k % WR_W)];
            end
         end
         assign w_bits[k] = bit_q;
      end else begin : g_pad
         assign w_bits[k] = 1'b0;
      end
   end

   // TAIL ticks in continuous mode emit bit 0 of the next frame
   assign w_idx = (state_q == ST_TAIL) ? '0 : bit_idx_q;
   assign w_raw = w_bits[w_idx];

`ifdef PHASE_TX_SCRAMBLE_EN
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] w_lfsr_cur, w_lfsr_next;
   logic       w_scr;

   assign w_lfsr_cur  = (state_q == ST_TAIL) ? RAND_SEED : lfsr_q;
   assign w_scr       = (32'(w_idx) >= ASM_BITS);
   assign w_data      = w_raw ^ (w_scr & w_lfsr_cur[0]);
   assign w_lfsr_next = w_scr ? {^(w_lfsr_cur & RAND_TAPS), w_lfsr_cur[7:1]} : w_lfsr_cur;
`else
   assign w_data = w_raw;
`endif

   always_comb begin
      case (mode_q)
         MODE_NRZM: w_phase_next = phase_q ^ w_data;
         MODE_NRZS: w_phase_next = phase_q ^ ~w_data;
         default:   w_phase_next = w_data;
      endcase
   end

   assign w_len_clamped = (32'(bus.frame_len) > MAX_BITS) ? LW'(MAX_BITS) : bus.frame_len;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      mode_d    = mode_q;
      bit_idx_d = bit_idx_q;
      phase_d   = phase_q;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
`ifdef PHASE_TX_SCRAMBLE_EN
      lfsr_d    = lfsr_q;
`endif
      if (bus.abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.send_signal && (bus.frame_len != '0)) begin
                  state_d   = ST_SEND;
                  len_d     = w_len_clamped;
                  mode_d    = mode_e'(bus.mode);
                  bit_idx_d = '0;
`ifdef PHASE_TX_SCRAMBLE_EN
                  lfsr_d    = RAND_SEED;
`endif
               end
            end
            ST_SEND: begin
               if (w_tick) begin
                  phase_d  = w_phase_next;
                  strobe_d = 1'b1;
`ifdef PHASE_TX_SCRAMBLE_EN
                  lfsr_d   = w_lfsr_next;
`endif
                  if (bit_idx_q == (len_q - LW'(1))) begin
                     state_d = ST_TAIL;
                  end else begin
                     bit_idx_d = bit_idx_q + LW'(1);
                  end
               end
            end
            ST_TAIL: begin
               if (w_tick) begin
                  done_d = 1'b1;
                  if (bus.continuous) begin
                     phase_d   = w_phase_next;
                     strobe_d  = 1'b1;
                     bit_idx_d = LW'(1);
                     state_d   = (len_q == LW'(1)) ? ST_TAIL : ST_SEND;
`ifdef PHASE_TX_SCRAMBLE_EN
                     lfsr_d    = w_lfsr_next;
`endif
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         mode_q    <= MODE_NRZL;
         bit_idx_q <= '0;
         phase_q   <= 1'b1;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
`ifdef PHASE_TX_SCRAMBLE_EN
         lfsr_q    <= RAND_SEED;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         bit_idx_q <= bit_idx_d;
         phase_q   <= phase_d;
         strobe_q  <= strobe_d;
         done_q    <= done_d;
`ifdef PHASE_TX_SCRAMBLE_EN
         lfsr_q    <= lfsr_d;
`endif
      end
   end

   assign bus.busy       = w_busy;
   assign bus.gen_en     = w_busy;
   assign bus.bit_strobe = strobe_q;
   assign bus.frame_done = done_q;
   assign bus.phase_ctrl = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_frame_tx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_phase_frame_tx : directed scoreboard bench for phase_frame_tx, DIV = 4 |
// | Revision          : 1.0                                                   |
// +---------------------------------------------------------------------------+
module tb_phase_frame_tx;
   import phase_tx_pkg::*;

   localparam int DIV  = 4;
   localparam int WR_W = 8;
`ifdef PHASE_TX_SCRAMBLE_EN
   localparam int MAXB = 48;
`else
   localparam int MAXB = 16;
`endif
   localparam int LW = lw_of(MAXB);
   localparam int AW = aw_of(depth_of(MAXB, WR_W));

   typedef struct { logic ph; int cyc; } sym_t;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   int          cyc     = 0;
   int          errors  = 0;
   int          checks  = 0;
   sym_t        sym_q[$];
   int          done_exp_q[$];
   logic        mbits [MAXB];
   logic        m_phase = 1'b1;
   logic [31:0] obs     = '0;
   sym_t        mon_e;
   int          mon_d;

   phase_frame_tx_if #(.MAX_BITS(MAXB), .WR_W(WR_W)) bus ();

   phase_frame_tx #(
      .REF_CLK_FREQ (40),
      .BAUDRATE     (10),
      .MAX_BITS     (MAXB),
      .WR_W         (WR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(int addr, logic [WR_W-1:0] data, bit model);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(addr);
      bus.wr_data = data;
      tick(1);
      bus.wr_en   = 1'b0;
      if (model)
         for (int j = 0; j < WR_W; j++) mbits[addr*WR_W + j] = data[WR_W-1-j];
   endtask

   task automatic start(int len, logic [1:0] md, output int s);
      bus.frame_len   = LW'(len);
      bus.mode        = md;
      bus.send_signal = 1'b1;
      tick(1);
      s = cyc;
      bus.send_signal = 1'b0;
   endtask

   // Independent line-coding model: expected level and cycle of each symbol
   task automatic push_frame(int s, int len, logic [1:0] md, int nsym, bit with_done);
      for (int k = 0; k < nsym; k++) begin
         case (md)
            2'b01:   m_phase = m_phase ^ mbits[k];
            2'b10:   m_phase = m_phase ^ ~mbits[k];
            default: m_phase = mbits[k];
         endcase
         sym_q.push_back('{ph: m_phase, cyc: s + DIV*(k+1)});
      end
      if (with_done) done_exp_q.push_back(s + DIV*(len+1));
   endtask

   task automatic wait_idle(string tag);
      for (int i = 0; i < 400 && bus.busy; i++) tick(1);
      chk(tag, 32'(bus.busy), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.bit_strobe) begin
         obs = {obs[30:0], bus.phase_ctrl};
         chk("strobe_expected", 32'(sym_q.size() != 0), 1);
         if (sym_q.size() != 0) begin
            mon_e = sym_q.pop_front();
            chk("sym_level", 32'(bus.phase_ctrl), 32'(mon_e.ph));
            chk("sym_cycle", cyc, mon_e.cyc);
         end
      end
      if (rst_n && bus.frame_done) begin
         chk("done_expected", 32'(done_exp_q.size() != 0), 1);
         if (done_exp_q.size() != 0) begin
            mon_d = done_exp_q.pop_front();
            chk("done_cycle", cyc, mon_d);
         end
      end
   end

   initial begin
      int s;
      logic [47:0] ex;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.frame_len = '0;
      bus.mode = 2'b00; bus.continuous = 1'b0; bus.send_signal = 1'b0; bus.abort = 1'b0;
      for (int i = 0; i < MAXB; i++) mbits[i] = 1'b0;
      ex = '0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("rst_phase", 32'(bus.phase_ctrl), 1);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_gen_en", 32'(bus.gen_en), 0);
      chk("rst_strobe", 32'(bus.bit_strobe), 0);
      chk("rst_done", 32'(bus.frame_done), 0);

`ifdef PHASE_TX_SCRAMBLE_EN
      ex = 48'h1ACF_FC1D_FF48;
      wr(0, 8'h1A, 0); wr(1, 8'hCF, 0); wr(2, 8'hFC, 0);
      wr(3, 8'h1D, 0); wr(4, 8'h00, 0); wr(5, 8'h00, 0);
      for (int f = 0; f < 2; f++) begin
         start(48, 2'b00, s);
         for (int k = 0; k < 48; k++) sym_q.push_back('{ph: ex[47-k], cyc: s + DIV*(k+1)});
         done_exp_q.push_back(s + DIV*49);
         wait_idle("scr_idle");
         chk("scr_tail16", obs[15:0], 16'hFF48);
      end
`else
      wr(0, 8'hA5, 1);
      wr(1, 8'h0F, 1);

      // NRZ-L one-shot, 16 bits
      start(16, 2'b00, s);
      push_frame(s, 16, 2'b00, 16, 1);
      chk("t1_busy", 32'(bus.busy), 1);
      chk("t1_gen_en", 32'(bus.gen_en), 1);
      for (int i = 0; i < 200 && !bus.frame_done; i++) tick(1);
      chk("t1_done_cyc", cyc, s + 68);
      chk("t1_busy_fall", 32'(bus.busy), 0);
      chk("t1_gen_en_fall", 32'(bus.gen_en), 0);
      chk("t1_symbols", obs[15:0], 16'hA50F);

      // NRZ-M from level 1
      start(16, 2'b01, s);
      push_frame(s, 16, 2'b01, 16, 1);
      wait_idle("t2_idle");
      chk("t2_symbols", obs[15:0], 16'h39F5);

      // Continuous NRZ-S, len 3, dropped during the third frame
      bus.continuous = 1'b1;
      start(3, 2'b10, s);
      for (int n = 0; n < 3; n++) push_frame(s + 12*n, 3, 2'b10, 3, 1);
      tick(32);
      chk("t3_busy_loop", 32'(bus.busy), 1);
      bus.continuous = 1'b0;
      wait_idle("t3_idle");
      chk("t3_stop_cyc", cyc, s + 40);

      // Abort sampled at cycle 10 of a frame
      start(16, 2'b00, s);
      push_frame(s, 16, 2'b00, 2, 0);
      tick(9);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      chk("t4_abort_busy", 32'(bus.busy), 0);
      chk("t4_abort_phase", 32'(bus.phase_ctrl), 32'(m_phase));
      tick(40);
      chk("t4_hold_phase", 32'(bus.phase_ctrl), 32'(m_phase));
      chk("t4_hold_busy", 32'(bus.busy), 0);

      // Abort together with send_signal
      bus.frame_len = LW'(16); bus.abort = 1'b1; bus.send_signal = 1'b1;
      tick(1);
      bus.abort = 1'b0; bus.send_signal = 1'b0;
      chk("t5_abort_send", 32'(bus.busy), 0);

      // Zero length start
      start(0, 2'b00, s);
      chk("t6_len0", 32'(bus.busy), 0);
      tick(20);
      chk("t6_len0_later", 32'(bus.busy), 0);

      // Length clamp with a write attempt while busy
      start(20, 2'b00, s);
      push_frame(s, 16, 2'b00, 16, 1);
      tick(5);
      wr(0, 8'h00, 0);
      wait_idle("t7_idle");
      chk("t7_clamp_end", cyc, s + 68);
      start(8, 2'b00, s);
      push_frame(s, 8, 2'b00, 8, 1);
      wait_idle("t8_idle");
      chk("t8_buf_kept", obs[7:0], 8'hA5);
`endif

      tick(4);
      chk("sym_q_drained", sym_q.size(), 0);
      chk("done_q_drained", done_exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
